fft_frame_loader: RTL and testbench

//  Upstream feeder for the combinational top_fft core.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_frame_bank.sv | 28 ++
 rtl/fft_frame_loader.sv | 110 +++++++++++
 tb/tb_fft_frame_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front-end: complex sample type,
// Re/Im index constants, bit-reversal helper and default sizing.
package fft_pkg;

  localparam int DEF_POINT_FFT_POW2 = 4;
  localparam int DEF_FRAC_BITS      = 15;

  localparam int RE = 0;
  localparam int IM = 1;

  typedef logic signed [1:0][DEF_FRAC_BITS:0] cplx_t;

  // Reverses the low 'width' bits of idx; upper bits return as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer: 2^ADDR_W complex registers, single write port, all slots read in parallel.
// Latency: write visible on rdata the cycle after we.
// Backpressure: none; the owner decides when to write.
module fft_frame_bank #(
  parameter int ADDR_W = 4,
  parameter int DW     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   waddr,
  input  logic [1:0][DW-1:0]                  wdata,
  output logic [(1<<ADDR_W)-1:0][1:0][DW-1:0] rdata
);

  logic [(1<<ADDR_W)-1:0][1:0][DW-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Packs a sample stream into ping-pong frames for top_fft; FFT_FRAME_LOADER_BITREV_EN stores bit-reversed.
// Latency: frame_valid_o rises 1 clk after the last sample of a frame is accepted.
// Backpressure: s_ready_o drops only when both banks hold untaken frames.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int POINT_FFT_POW2 = DEF_POINT_FFT_POW2,
  parameter int FRAC_BITS      = DEF_FRAC_BITS
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         s_valid_i,
  output logic                                         s_ready_o,
  input  logic [1:0][FRAC_BITS:0]                      s_data_i,
  output logic                                         frame_valid_o,
  input  logic                                         frame_ready_i,
  output logic [(1<<POINT_FFT_POW2)-1:0][1:0][FRAC_BITS:0] frame_o,
  output logic [15:0]                                  frame_cnt_o
);

  localparam int POINT_FFT = 1 << POINT_FFT_POW2;
  localparam int DW        = FRAC_BITS + 1;

  logic [1:0]                full_q, full_d;
  logic                      wr_sel_q, wr_sel_d;
  logic                      rd_sel_q, rd_sel_d;
  logic [POINT_FFT_POW2-1:0] wr_idx_q, wr_idx_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;

  logic                      accept, frame_done, handoff;
  logic [POINT_FFT_POW2-1:0] wr_slot;
  logic [POINT_FFT-1:0][1:0][DW-1:0] rdata0, rdata1;

`ifdef FFT_FRAME_LOADER_BITREV_EN
  assign wr_slot = POINT_FFT_POW2'(bitrev(32'(wr_idx_q), POINT_FFT_POW2));
`else
  assign wr_slot = wr_idx_q;
`endif

  assign s_ready_o     = !full_q[wr_sel_q];
  assign frame_valid_o = full_q[rd_sel_q];
  assign frame_o       = rd_sel_q ? rdata1 : rdata0;
  assign frame_cnt_o   = frame_cnt_q;

  assign accept     = s_valid_i & s_ready_o & !flush_i;
  assign frame_done = accept & (&wr_idx_q);
  assign handoff    = frame_valid_o & frame_ready_i;

  fft_frame_bank #(.ADDR_W(POINT_FFT_POW2), .DW(DW)) u_bank0 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (accept & !wr_sel_q),
    .waddr (wr_slot),
    .wdata (s_data_i),
    .rdata (rdata0)
  );

  fft_frame_bank #(.ADDR_W(POINT_FFT_POW2), .DW(DW)) u_bank1 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (accept & wr_sel_q),
    .waddr (wr_slot),
    .wdata (s_data_i),
    .rdata (rdata1)
  );

  // Completion and handoff always target different banks, so both may apply together.
  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_idx_d    = wr_idx_q;
    frame_cnt_d = frame_cnt_q;

    if (flush_i) begin
      wr_idx_d = '0;
    end else if (accept) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end

    if (frame_done) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end

    if (handoff) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
      frame_cnt_d      = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_idx_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_idx_q    <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: queue-level frame model checked every cycle plus directed literal pins.
module tb_fft_frame_loader;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  s_valid;
  logic                  s_ready;
  logic [1:0][15:0]      s_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [15:0][1:0][15:0] frame_o;
  logic [15:0]           frame_cnt;

  fft_frame_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
    .frame_valid_o(frame_valid),
    .frame_ready_i(frame_ready),
    .frame_o      (frame_o),
    .frame_cnt_o  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit done   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int bm(input int k);
    logic [3:0] v;
    v = 4'(k);
`ifdef FFT_FRAME_LOADER_BITREV_EN
    return int'({v[0], v[1], v[2], v[3]});
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [31:0] smp(input logic [15:0] re, input logic [15:0] im);
    return {im, re};
  endfunction

  // Model: up to two completed frames in a FIFO, plus the frame being filled.
  logic [31:0] mpart [16];
  logic [31:0] mfrm  [2][16];
  int          mcount, mhead, midx, acc_cnt;
  logic [15:0] mcnt;

  always @(posedge clk or negedge rst_n) begin
    bit acc, take, pushed;
    int slot;
    if (!rst_n) begin
      mcount  = 0;
      mhead   = 0;
      midx    = 0;
      mcnt    = '0;
      acc_cnt = 0;
    end else begin
      acc    = s_valid && (mcount < 2) && !flush;
      take   = (mcount > 0) && frame_ready;
      pushed = 0;
      if (flush) begin
        midx = 0;
      end else if (acc) begin
        acc_cnt++;
        mpart[bm(midx)] = s_data;
        if (midx == 15) begin
          slot = (mhead + mcount) % 2;
          for (int i = 0; i < 16; i++) mfrm[slot][i] = mpart[i];
          pushed = 1;
          midx = 0;
        end else begin
          midx++;
        end
      end
      if (take) begin
        mhead = mhead ^ 1;
        mcnt  = mcnt + 16'd1;
      end
      mcount = mcount + int'(pushed) - int'(take);
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("s_ready", 32'(s_ready), 32'(mcount < 2));
      chk("frame_valid", 32'(frame_valid), 32'(mcount > 0));
      chk("frame_cnt", 32'(frame_cnt), 32'(mcnt));
      if (mcount > 0) begin
        for (int s = 0; s < 16; s++) chk("frame_o", frame_o[s], mfrm[mhead][s]);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic fr, input logic fl);
    s_valid     = v;
    s_data      = d;
    frame_ready = fr;
    flush       = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 0; flush = 0; frame_ready = 0; s_data = '0;
    rst_n = 0;
    @(negedge clk); #1;
    rst_n = 1;
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 0; s_valid = 0; flush = 0; frame_ready = 0; s_data = '0;
    @(negedge clk); #1;

    // Reset values
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame0", frame_o[0], 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1;
    @(negedge clk); #1;

    // 1: reset mid-frame
    for (int k = 0; k < 7; k++) step(1, smp(16'h7000 + 16'(k), 16'(k)), 0, 0);
    s_valid = 0;
    rst_n = 0;
    @(negedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("t1_valid_early", 32'(frame_valid), 32'd0);
      step(1, smp(16'h2000 + 16'(k), 16'(k)), 0, 0);
    end
    chk("t1_valid", 32'(frame_valid), 32'd1);
    chk("t1_first", frame_o[bm(0)], smp(16'h2000, 16'h0000));

    // 2: ramp with consumer ready
    do_reset();
    for (int n = 0; n < 16; n++) begin
      if (n == 15) chk("t2_valid_early", 32'(frame_valid), 32'd0);
      step(1, smp(16'(n) << 8, -16'(n)), 1, 0);
    end
    chk("t2_valid", 32'(frame_valid), 32'd1);
    chk("t2_slot5", frame_o[bm(5)], 32'hFFFB_0500);
    chk("t2_slot15", frame_o[bm(15)], 32'hFFF1_0F00);
    step(0, '0, 1, 0);
    chk("t2_cnt", 32'(frame_cnt), 32'd1);

    // 3: backpressure
    do_reset();
    for (int k = 0; k < 40; k++) step(1, smp(16'h3000 + 16'(k), 16'(k)), 0, 0);
    chk("t3_accepted", 32'(acc_cnt), 32'd32);
    chk("t3_s_ready", 32'(s_ready), 32'd0);
    chk("t3_hold", frame_o[bm(0)], smp(16'h3000, 16'h0000));
    step(0, '0, 1, 0);
    chk("t3_reopen", 32'(s_ready), 32'd1);
    chk("t3_next", frame_o[bm(0)], smp(16'h3010, 16'h0010));
    step(0, '0, 1, 0);
    chk("t3_cnt", 32'(frame_cnt), 32'd2);

    // 4: completion and handoff in the same cycle
    do_reset();
    for (int k = 0; k < 31; k++) step(1, smp(16'h4000 + 16'(k), 16'(k)), 0, 0);
    step(1, smp(16'h401F, 16'h001F), 1, 0);
    chk("t4_valid", 32'(frame_valid), 32'd1);
    chk("t4_cnt", 32'(frame_cnt), 32'd1);
    chk("t4_first", frame_o[bm(0)], smp(16'h4010, 16'h0010));
    chk("t4_last", frame_o[bm(15)], smp(16'h401F, 16'h001F));
    step(0, '0, 1, 0);

    // 5: flush
    do_reset();
    for (int k = 0; k < 5; k++) step(1, smp(16'h5000 + 16'(k), 16'(k)), 0, 0);
    step(1, smp(16'hDEAD, 16'hBEEF), 0, 1);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("t5_valid_early", 32'(frame_valid), 32'd0);
      step(1, smp(16'h1000 + 16'(k), 16'h0000), 0, 0);
    end
    chk("t5_valid", 32'(frame_valid), 32'd1);
    chk("t5_first", frame_o[bm(0)], smp(16'h1000, 16'h0000));
    chk("t5_last", frame_o[bm(15)], smp(16'h100F, 16'h0000));

    // 6: slot placement
    do_reset();
    for (int k = 0; k < 16; k++) step(1, smp(16'(k), 16'h0000), 0, 0);
`ifdef FFT_FRAME_LOADER_BITREV_EN
    chk("t6_slot1", frame_o[1], smp(16'd8, 16'd0));
    chk("t6_slot3", frame_o[3], smp(16'd12, 16'd0));
    chk("t6_slot15", frame_o[15], smp(16'd15, 16'd0));
`else
    chk("t6_slot1", frame_o[1], smp(16'd1, 16'd0));
    chk("t6_slot3", frame_o[3], smp(16'd3, 16'd0));
    chk("t6_slot15", frame_o[15], smp(16'd15, 16'd0));
`endif
    step(0, '0, 1, 0);

    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
